switch_debounce: RTL and testbench
==================================

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

Interface
REQ-001 Parameter NUM_SW, default 2, SHALL set the number of independent switch channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 12000, SHALL set the consecutive stable cycles (1 ms at 12 MHz) needed to accept a new level; legal range 2..65535.
REQ-003 Parameter CNT_W, default 16, SHALL set the debounce counter width; CNT_W SHALL hold DEBOUNCE_CYCLES-1.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 sw_raw  input  NUM_SW  raw switch pins, asynchronous to clk, 1 = pressed.
REQ-008 sw_level  output  NUM_SW  debounced switch level, registered.
REQ-009 sw_press  output  NUM_SW  one-cycle pulse on accepted 0->1 transition.
REQ-010 sw_release  output  NUM_SW  one-cycle pulse on accepted 1->0 transition.
REQ-011 sw_toggle  output  NUM_SW  per-channel bit inverted on each press, for direct LED drive.
REQ-012 press_count  output  8*NUM_SW  per-channel 8-bit press counter, channel i in bits [8i+7:8i].

Function
REQ-013 Each channel SHALL pass sw_raw through a two-flop synchronizer; the second stage is the sampled value s.
REQ-014 Each channel SHALL hold a CNT_W-bit counter cnt and a level register.
REQ-015 On each edge with s == level, cnt SHALL load 0.
REQ-016 On each edge with s != level and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-017 On each edge with s != level and cnt == DEBOUNCE_CYCLES-1, level SHALL load s and cnt SHALL load 0.
REQ-018 A raw change held stable from before edge 0 SHALL appear on sw_level after edge DEBOUNCE_CYCLES+1 (2 sync + DEBOUNCE_CYCLES).
REQ-019 Any return of s to level before acceptance SHALL discard progress (cnt to 0); glitches shorter than DEBOUNCE_CYCLES cycles SHALL never reach sw_level.
REQ-020 sw_press SHALL be high for exactly the one cycle following the edge where level goes 0->1; sw_release likewise for 1->0; both registered, never high together on a channel.
REQ-021 sw_toggle SHALL invert on the same edge that raises sw_press.
REQ-022 press_count SHALL increment by 1 on the same edge that raises sw_press, wrapping 255 -> 0 without flag.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be handled in the same cycle.
REQ-024 No pulse SHALL be generated from reset deassertion itself, even if sw_raw is 1 at that time; a held-high switch SHALL produce one press DEBOUNCE_CYCLES+2 cycles after reset release.

Reset
REQ-025 While rst_n is low, synchronizer flops, cnt, sw_level, sw_press, sw_release, sw_toggle and press_count SHALL all be 0.
REQ-026 Reset asserted mid-debounce SHALL abandon the pending transition immediately; no pulse SHALL be emitted for it.
REQ-027 Reset SHALL be applied asynchronously; deassertion is assumed synchronized externally to clk.

Verification (DEBOUNCE_CYCLES=4, NUM_SW=2)
REQ-028 Clean press: sw_raw[0] 0->1 held -> sw_level[0]=1 after edge 5, sw_press[0] one cycle, press_count[7:0]=1, sw_toggle[0]=1; channel 1 unchanged.
REQ-029 Bounce: sw_raw[0] high 3 cycles, low 1, high held -> no pulse during bounce, sw_level[0] rises 6 cycles after final rise; exactly one press.
REQ-030 Release: from level 1, sw_raw[0] to 0 held -> sw_release[0] one cycle, press_count unchanged, sw_toggle unchanged.
REQ-031 Wrap: 256 clean presses on channel 1 -> press_count[15:8]=0, sw_toggle[1]=0 at end.
REQ-032 Simultaneous: both sw_raw bits rise on same edge -> both sw_press bits pulse in the same cycle.
REQ-033 Reset mid-debounce: rst_n low at cnt=2 then released with sw_raw[0]=1 -> no pulse during reset, one press 6 cycles after release, outputs 0 throughout reset.

Source files
------------

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer: two-flop synchronizer, per-channel stability counter,
// registered level, press/release pulses, toggle bit and 8-bit press counter.
module switch_debounce #(
   parameter int NUM_SW          = 2,
   parameter int DEBOUNCE_CYCLES = 12000,
   parameter int CNT_W           = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_SW-1:0]     sw_raw,
   output logic [NUM_SW-1:0]     sw_level,
   output logic [NUM_SW-1:0]     sw_press,
   output logic [NUM_SW-1:0]     sw_release,
   output logic [NUM_SW-1:0]     sw_toggle,
   output logic [8*NUM_SW-1:0]   press_count
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [NUM_SW-1:0] sync1;
   logic [NUM_SW-1:0] sync2;
   logic [CNT_W-1:0]  cnt [NUM_SW];

   // A mismatch must persist for DEBOUNCE_CYCLES consecutive samples; any match restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1       <= '0;
         sync2       <= '0;
         sw_level    <= '0;
         sw_press    <= '0;
         sw_release  <= '0;
         sw_toggle   <= '0;
         press_count <= '0;
         for (int i = 0; i < NUM_SW; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
         for (int i = 0; i < NUM_SW; i++) begin
            sw_press[i]   <= 1'b0;
            sw_release[i] <= 1'b0;
            if (sync2[i] == sw_level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] < LAST) begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end else begin
               cnt[i]        <= '0;
               sw_level[i]   <= sync2[i];
               sw_press[i]   <= sync2[i];
               sw_release[i] <= ~sync2[i];
               if (sync2[i]) begin
                  sw_toggle[i]          <= ~sw_toggle[i];
                  press_count[8*i +: 8] <= press_count[8*i +: 8] + 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: window-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations and randomized bouncing.
module tb_switch_debounce;
   localparam int NUM_SW = 2;
   localparam int DEB    = 4;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [1:0]        sw_raw = 2'b00;
   logic [1:0]        sw_level, sw_press, sw_release, sw_toggle;
   logic [15:0]       press_count;

   switch_debounce #(.NUM_SW(NUM_SW), .DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .sw_level(sw_level), .sw_press(sw_press),
      .sw_release(sw_release), .sw_toggle(sw_toggle), .press_count(press_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;
   bit cmp_en = 1'b0;
   int press0_seen = 0;

   // Reference model: a channel accepts the opposite level once the last DEB synchronized
   // samples all disagree with the current level; samples lag the raw pin by two edges.
   logic [1:0]     raw_h1, raw_h2, s;
   logic [DEB-1:0] win [2];
   logic [1:0]     m_level, m_press, m_rel, m_tog;
   logic [7:0]     m_cnt [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raw_h1 = '0; raw_h2 = '0;
         m_level = '0; m_press = '0; m_rel = '0; m_tog = '0;
         for (int c = 0; c < 2; c++) begin
            win[c] = '0;
            m_cnt[c] = '0;
         end
      end else begin
         s = raw_h2;
         raw_h2 = raw_h1;
         raw_h1 = sw_raw;
         for (int c = 0; c < 2; c++) begin
            m_press[c] = 1'b0;
            m_rel[c] = 1'b0;
            win[c] = {win[c][DEB-2:0], s[c]};
            if (win[c] == {DEB{~m_level[c]}}) begin
               m_level[c] = ~m_level[c];
               if (m_level[c]) begin
                  m_press[c] = 1'b1;
                  m_tog[c] = ~m_tog[c];
                  m_cnt[c] = m_cnt[c] + 8'd1;
               end else begin
                  m_rel[c] = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         total++;
         if ({sw_level, sw_press, sw_release, sw_toggle, press_count} ===
             {m_level, m_press, m_rel, m_tog, m_cnt[1], m_cnt[0]})
            passed++;
         else
            $display("FAIL model_cmp t=%0t: dut lvl=%b prs=%b rel=%b tog=%b cnt=%h, model lvl=%b prs=%b rel=%b tog=%b cnt=%h",
                     $time, sw_level, sw_press, sw_release, sw_toggle, press_count,
                     m_level, m_press, m_rel, m_tog, {m_cnt[1], m_cnt[0]});
         if (sw_press[0] === 1'b1) press0_seen++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      #2 rst_n = 1'b0;
      tick(n);
      #2 rst_n = 1'b1;
   endtask

   int p0;

   initial begin
      tick(1);
      cmp_en = 1'b1;
      chk("reset_level", sw_level, 0);
      chk("reset_count", press_count, 0);
      tick(1);
      #2 rst_n = 1'b1;
      tick(3);

      // clean press on channel 0
      sw_raw = 2'b01;
      tick(5);
      chk("press_not_early", sw_level, 2'b00);
      tick(1);
      chk("press_level", sw_level, 2'b01);
      chk("press_pulse", sw_press, 2'b01);
      tick(1);
      chk("press_pulse_end", sw_press, 2'b00);
      chk("press_count1", press_count, 16'h0001);
      chk("press_toggle", sw_toggle, 2'b01);

      // release
      sw_raw = 2'b00;
      tick(5);
      chk("release_not_early", sw_level, 2'b01);
      tick(1);
      chk("release_pulse", sw_release, 2'b01);
      chk("release_level", sw_level, 2'b00);
      tick(1);
      chk("release_pulse_end", sw_release, 2'b00);
      chk("release_count", press_count, 16'h0001);
      chk("release_toggle", sw_toggle, 2'b01);

      // bounce: high 3, low 1, then held
      p0 = press0_seen;
      sw_raw = 2'b01; tick(3);
      sw_raw = 2'b00; tick(1);
      sw_raw = 2'b01; tick(5);
      chk("bounce_no_press", press0_seen - p0, 0);
      chk("bounce_level_low", sw_level, 2'b00);
      tick(1);
      chk("bounce_level", sw_level, 2'b01);
      chk("bounce_pulse", sw_press, 2'b01);
      tick(4);
      chk("bounce_one_press", press0_seen - p0, 1);
      sw_raw = 2'b00; tick(8);

      // wrap on channel 1 from a fresh reset
      do_reset(2);
      for (int k = 0; k < 255; k++) begin
         sw_raw = 2'b10; tick(7);
         sw_raw = 2'b00; tick(7);
      end
      chk("wrap_count255", press_count[15:8], 8'd255);
      chk("wrap_toggle_255", sw_toggle[1], 1'b1);
      sw_raw = 2'b10; tick(7);
      sw_raw = 2'b00; tick(7);
      chk("wrap_count0", press_count[15:8], 8'd0);
      chk("wrap_toggle", sw_toggle[1], 1'b0);
      chk("wrap_ch0_untouched", press_count[7:0], 8'd0);

      // simultaneous press
      sw_raw = 2'b11;
      tick(6);
      chk("simul_pulse", sw_press, 2'b11);
      tick(1);
      chk("simul_level", sw_level, 2'b11);
      sw_raw = 2'b00; tick(8);

      // reset in the middle of a debounce
      sw_raw = 2'b01;
      tick(4);
      #2 rst_n = 1'b0;
      tick(1);
      chk("rst_outputs_zero", {sw_level, sw_press, sw_release, sw_toggle, press_count}, 0);
      tick(2);
      #2 rst_n = 1'b1;
      tick(5);
      chk("rst_no_early_press", sw_press, 2'b00);
      tick(1);
      chk("rst_press_after", sw_press, 2'b01);
      chk("rst_press_count", press_count, 16'h0001);
      sw_raw = 2'b00; tick(8);

      // randomized bouncing with occasional resets
      for (int k = 0; k < 400; k++) begin
         sw_raw = 2'($urandom_range(0, 3));
         tick($urandom_range(1, 8));
         if ($urandom_range(0, 49) == 0) do_reset(2);
      end
      tick(2);
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
